// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: area-minimal bit-serial adder. One shared full-adder
// cell is stepped LSB-first through WIDTH bits, one bit per clock, with a
// registered carry loop. The result is published with a one-cycle done pulse.

// Single-bit full adder, the only arithmetic cell in the sequencer.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of three input bits.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] sreg;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit_c;
  logic [WIDTH-1:0] sreg_next_c;

  // Shared full-adder cell working on the current LSBs and the carry flop.
  fulladder u_fa (
    .a  (areg[0]),
    .b  (breg[0]),
    .ci (cy),
    .s  (fa_sum),
    .co (fa_carry)
  );

  // Final-bit detect and the next value of the result shift register.
  always_comb begin
    last_bit_c  = (cnt == CW'(WIDTH - 1));
    sreg_next_c = {fa_sum, sreg[WIDTH-1:1]};
  end

  // Sequencer: operand capture, serial stepping, result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      cy    <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // A start in DONE is accepted directly for back-to-back operation.
          if (start) begin
            areg  <= a;
            breg  <= b;
            cy    <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sreg <= sreg_next_c;
          areg <= areg >> 1;
          breg <= breg >> 1;
          cy   <= fa_carry;
          cnt  <= cnt + CW'(1);
          if (last_bit_c) begin
            // Publish only complete results so sum/cout never show partials.
            sum   <= sreg_next_c;
            cout  <= fa_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 (directed + random) and
// WIDTH=13 (random) instances run concurrently against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_serial_adder_ctrl;

  typedef struct {
    logic [63:0] s;
    logic        co;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0;
  logic        busy8, done8, cout8;
  logic [7:0]  sum8;

  logic        start13 = 1'b0;
  logic [12:0] a13 = '0, b13 = '0;
  logic        cin13 = 1'b0;
  logic        busy13, done13, cout13;
  logic [12:0] sum13;

  exp_t q8[$];
  exp_t q13[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(13)) u13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Issue one addition on the 8-bit instance; must be called at a negedge.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic c);
    exp_t e;
    logic [8:0] r;
    int n = 0;
    while (busy8 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("issue8_wait_timeout", 64'(n), 64'(0));
    r = 9'(x) + 9'(y) + 9'(c);
    e.s = 64'(r[7:0]); e.co = r[8]; e.cyc = cyc + 9;
    q8.push_back(e);
    a8 = x; b8 = y; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic issue13(input logic [12:0] x, input logic [12:0] y, input logic c);
    exp_t e;
    logic [13:0] r;
    int n = 0;
    while (busy13 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("issue13_wait_timeout", 64'(n), 64'(0));
    r = 14'(x) + 14'(y) + 14'(c);
    e.s = 64'(r[12:0]); e.co = r[13]; e.cyc = cyc + 14;
    q13.push_back(e);
    a13 = x; b13 = y; cin13 = c; start13 = 1'b1;
    @(negedge clk);
    start13 = 1'b0;
    a13 = 13'($urandom); b13 = 13'($urandom);
  endtask

  // Monitor for the 8-bit instance: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy8 && done8) check("busy8_and_done8", 64'(1), 64'(0));
      if (done8) begin
        if (q8.size() == 0) check("spurious_done8", 64'(1), 64'(0));
        else begin
          exp_t e;
          e = q8.pop_front();
          check("sum8", 64'(sum8), e.s);
          check("cout8", 64'(cout8), 64'(e.co));
          check("latency8_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Monitor for the 13-bit instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy13 && done13) check("busy13_and_done13", 64'(1), 64'(0));
      if (done13) begin
        if (q13.size() == 0) check("spurious_done13", 64'(1), 64'(0));
        else begin
          exp_t e;
          e = q13.pop_front();
          check("sum13", 64'(sum13), e.s);
          check("cout13", 64'(cout13), 64'(e.co));
          check("latency13_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy8", 64'(busy8), 64'(0));
    check("reset_done8", 64'(done8), 64'(0));
    check("reset_sum8", 64'(sum8), 64'(0));
    check("reset_cout8", 64'(cout8), 64'(0));
    check("reset_sum13", 64'(sum13), 64'(0));

    fork
      begin
        // 0x0F + 0x01: busy for 8 cycles, done in the 9th.
        issue8(8'h0F, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) begin
          check("busy8_during_run", 64'(busy8), 64'(1));
          @(negedge clk);
        end
        check("done8_ninth_cycle", 64'(done8), 64'(1));
        check("busy8_at_done", 64'(busy8), 64'(0));

        issue8(8'hFF, 8'h01, 1'b0);
        issue8(8'hFF, 8'hFF, 1'b1);
        issue8(8'h00, 8'h00, 1'b0);

        // Start pulses while running are ignored.
        issue8(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);

        // Back-to-back: second start accepted in the DONE cycle.
        issue8(8'h80, 8'h80, 1'b0);
        issue8(8'h01, 8'h02, 1'b0);
        for (int i = 0; i < 6; i++) begin
          check("sum8_hold_between", 64'(sum8), 64'(0));
          check("cout8_hold_between", 64'(cout8), 64'(1));
          @(negedge clk);
        end
        n = 0;
        while (q8.size() != 0 && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);

        // Reset at the 4th RUN edge aborts the computation.
        issue8(8'h77, 8'h11, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q8.delete();
        check("abort_busy8", 64'(busy8), 64'(0));
        check("abort_done8", 64'(done8), 64'(0));
        check("abort_sum8", 64'(sum8), 64'(0));
        check("abort_cout8", 64'(cout8), 64'(0));
        repeat (15) @(negedge clk);
        issue8(8'h05, 8'h03, 1'b0);

        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
          issue8(8'($urandom), 8'($urandom), 1'($urandom));
        end
      end
      begin
        // The 13-bit instance is reset by the abort above too; start after it.
        repeat (150) @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
          issue13(13'($urandom), 13'($urandom), 1'($urandom));
        end
      end
    join

    n = 0;
    while ((q8.size() != 0 || q13.size() != 0) && n < 200) begin @(negedge clk); n++; end
    check("drain_q8_empty", 64'(q8.size()), 64'(0));
    check("drain_q13_empty", 64'(q13.size()), 64'(0));
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
